// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-NCH valid/ready stream demultiplexer.
//
// The destination channel is sampled from in_sel on the first beat of a packet and
// held until the beat carrying in_last. Packets whose first-beat select is out of
// range (>= NCH) are accepted and discarded as a whole. Each output channel has a
// one-entry register, so a stalled channel never blocks draining of the others.
//
// Optional feature (macro STREAM_DEMUX_DROP_CNT_EN): adds output drop_cnt, a
// saturating count of discarded beats.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_data, in_sel, in_last carried with it
//   out_valid/out_ready   per-channel handshake, bit i is channel i
//   out_data              channel i occupies [i*DW +: DW]
//   out_last              per-channel last flag
//   busy                  a packet is open (routing or discarding)
//   cur_ch                locked channel, 0 when idle
//   drop_cnt              discarded-beat counter (macro builds only)
module stream_demux_1ton #(
  parameter int unsigned DW  = 8,
  parameter int unsigned NCH = 4,
  parameter int unsigned SW  = 2,
  parameter int unsigned CW  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic [SW-1:0]     in_sel,
  input  logic              in_last,
  output logic [NCH-1:0]    out_valid,
  input  logic [NCH-1:0]    out_ready,
  output logic [NCH*DW-1:0] out_data,
  output logic [NCH-1:0]    out_last,
  output logic              busy,
  output logic [SW-1:0]     cur_ch
`ifdef STREAM_DEMUX_DROP_CNT_EN
  ,
  output logic [CW-1:0]     drop_cnt
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StPkt  = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     cur_ch_q, cur_ch_d;
  logic [NCH-1:0]    out_valid_q, out_valid_d;
  logic [NCH-1:0]    out_last_q, out_last_d;
  logic [NCH*DW-1:0] out_data_q, out_data_d;

  logic          sel_ok;
  logic [SW-1:0] tgt;
  logic          tgt_free;
  logic          load;
  logic          drop_beat;

  assign sel_ok = 32'(in_sel) < NCH;
  assign tgt    = (state_q == StIdle) ? in_sel : cur_ch_q;

  // Target register can take a beat if empty or draining this cycle. Decoded by loop
  // so an out-of-range select never indexes past the channel array.
  always_comb begin
    tgt_free = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (tgt == SW'(i)) tgt_free = !out_valid_q[i] || out_ready[i];
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    load      = 1'b0;
    drop_beat = 1'b0;
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    case (state_q)
      StIdle: begin
        in_ready = sel_ok ? tgt_free : 1'b1;
        if (in_valid && in_ready) begin
          load      = sel_ok;
          drop_beat = !sel_ok;
          if (!in_last) begin
            if (sel_ok) begin
              state_d  = StPkt;
              cur_ch_d = in_sel;
            end else begin
              state_d = StDrop;
            end
          end
        end
      end
      StPkt: begin
        in_ready = tgt_free;
        if (in_valid && in_ready) begin
          load = 1'b1;
          if (in_last) begin
            state_d  = StIdle;
            cur_ch_d = '0;
          end
        end
      end
      StDrop: begin
        in_ready = 1'b1;
        if (in_valid) begin
          drop_beat = 1'b1;
          if (in_last) state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        cur_ch_d = '0;
      end
    endcase
  end

  // Load wins over drain, so a simultaneous drain+load keeps valid high.
  always_comb begin
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (load && tgt == SW'(i)) begin
        out_valid_d[i]           = 1'b1;
        out_last_d[i]            = in_last;
        out_data_d[i*DW +: DW]   = in_data;
      end else if (out_ready[i]) begin
        out_valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cur_ch_q    <= '0;
      out_valid_q <= '0;
      out_last_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign busy      = state_q != StIdle;
  assign cur_ch    = cur_ch_q;

`ifdef STREAM_DEMUX_DROP_CNT_EN
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_beat && drop_cnt_q != {CW{1'b1}}) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  logic unused_drop_beat;
  assign unused_drop_beat = drop_beat;
`endif

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised, registered successor to the 1-to-4 combinational demultiplexer.
- Routes a valid/ready input stream to one of NCH output channels, each with its own valid/ready handshake and a one-entry output register.
- Channel select is sampled on the first beat of a packet and locked until in_last.
- Out-of-range selects discard the whole packet instead of driving X/Z.
- Sits between a packet source and NCH per-channel consumers.

Parameters:
- DW, 8, data width in bits.
- NCH, 4, number of output channels, 2..16.
- SW, 2, select width; must satisfy 2**SW >= NCH.
- CW, 8, width of the drop counter (optional feature only).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  DW  input beat data.
- in_sel  in  SW  destination channel; sampled only on the first beat of a packet.
- in_last  in  1  marks the final beat of a packet.
- out_valid  out  NCH  per-channel valid; bit i belongs to channel i.
- out_ready  in  NCH  per-channel ready.
- out_data  out  NCH*DW  channel i occupies bits [i*DW +: DW].
- out_last  out  NCH  per-channel last flag.
- busy  out  1  high while a packet is open (state PKT or DROP).
- cur_ch  out  SW  locked channel; 0 when IDLE.

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_data=0, out_last=0.
  - state=IDLE, cur_ch=0, busy=0, drop counter=0.
  - Takes effect immediately. Any open packet is abandoned with no recovery; the next accepted beat is treated as a first beat.
- FSM states: IDLE, PKT, DROP.
- Target channel:
  - IDLE: tgt = in_sel.
  - PKT: tgt = cur_ch.
  - In DROP, tgt is unused.
- in_ready (combinational):
  - DROP: 1.
  - IDLE with in_sel >= NCH: 1.
  - Otherwise: !out_valid[tgt] | out_ready[tgt].
- Accepted beat (in_valid & in_ready):
  - In IDLE with in_sel < NCH, or in PKT: at the next edge out_data[tgt]<=in_data, out_last[tgt]<=in_last, out_valid[tgt]<=1.
  - Otherwise the beat is discarded.
- Transitions, evaluated on accepted beats only:
  - IDLE, in_last=1: stay IDLE (single-beat packet).
  - IDLE, in_last=0, in_sel < NCH: go to PKT, cur_ch<=in_sel.
  - IDLE, in_last=0, in_sel >= NCH: go to DROP.
  - PKT, in_last=1: go to IDLE, cur_ch<=0.
  - DROP, in_last=1: go to IDLE.
  - in_sel is ignored in PKT and DROP.
- Latency: 1 cycle from acceptance to out_valid.
- Per-channel throughput: 1 beat/cycle when out_ready is held high.
- Channel register:
  - Cleared (out_valid[i]<=0) on out_valid[i] & out_ready[i] with no load that cycle.
  - Drain and load in the same cycle: new data is written and out_valid stays 1.
- Non-selected channels hold their contents and drain independently; a stall on one channel never blocks draining of the others.
- out_data for a channel with out_valid=0 holds its last value. Never X or Z.
- in_valid=0: no state change. out_ready must not combinationally depend on in_valid.
- in_sel values >= NCH (including unused codes when NCH < 2**SW) are legal and take the drop path.

Optional Feature:
- Macro: STREAM_DEMUX_DROP_CNT_EN.
- Defined:
  - Adds output port drop_cnt (out, CW).
  - Increments by 1 on every beat discarded (IDLE/out-of-range or DROP).
  - Saturates at 2**CW-1 and resets to 0.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Route: NCH=4, all out_ready=1. Single-beat packets with sel=0,1,2,3 and data A0,A1,A2,A3 -> each out_valid[i] pulses 1 cycle after acceptance with matching data; out_last=1; other channels stay 0.
- Lock: 3-beat packet, first beat sel=2, later beats sel=0 -> all 3 beats appear on channel 2; busy=1 and cur_ch=2 until the last beat; then IDLE with cur_ch=0.
- Backpressure: out_ready[1]=0 with a 2-beat packet to channel 1 -> first beat held; in_ready=0 on the second beat until out_ready[1]=1; a simultaneous packet to channel 3 drains once channel 1 frees; no data loss.
- Drop: NCH=3, sel=3, 4-beat packet -> in_ready=1 for all beats; no out_valid; drop_cnt=4 with the macro defined; the following packet to channel 0 is delivered normally.
- Reset: assert rst_n low mid-packet (PKT, cur_ch=1, out_valid[1]=1) -> all outputs 0 asynchronously; after release a beat with sel=2 is treated as a first beat.
